// File: rtl/a_ref_cal_if.sv
// Bus bundle for the reference-generator calibrator: oscillator input,
// control/target inputs and the delay-code/status outputs.
interface a_ref_cal_if #(
  parameter int CNT_W = 16
);
  logic             i_osc;
  logic             i_start;
  logic             i_abort;
  logic [CNT_W-1:0] i_target;
  logic [7:0]       i_tol;
  logic [8:0]       o_dly_sel;
  logic             o_mode;
  logic             o_busy;
  logic             o_done;
  logic             o_lock;
  logic [CNT_W-1:0] o_cnt;

  modport slave (
    input  i_osc, i_start, i_abort, i_target, i_tol,
    output o_dly_sel, o_mode, o_busy, o_done, o_lock, o_cnt
  );

  modport master (
    output i_osc, i_start, i_abort, i_target, i_tol,
    input  o_dly_sel, o_mode, o_busy, o_done, o_lock, o_cnt
  );
endinterface

// File: rtl/a_ref_cal.sv
// Ring-oscillator delay calibrator: 9-bit successive approximation of the delay
// code against a target edge count, followed by one verify measurement.
module a_ref_cal #(
  parameter int WIN_CYC    = 256,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 16
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  a_ref_cal_if.slave bus
);
  localparam int TMR_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, DECIDE, DONE} state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       kbit_q, kbit_d;
  logic             verify_q, verify_d;
  logic [2:0]       osc_s_q, osc_s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic [7:0]       tol_q, tol_d;
  logic [8:0]       rest_q, rest_d;
  logic [8:0]       dly_q, dly_d;
  logic             mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             lock_q, lock_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;

  logic             osc_rise;
  logic [CNT_W-1:0] diff;
  logic [3:0]       kbit_m1;

  // osc_s_q[1] is the synchronized level; osc_s_q[2] is its one-cycle delay
  assign osc_rise = osc_s_q[1] & ~osc_s_q[2];
  assign diff     = (cnt_q >= tgt_q) ? (cnt_q - tgt_q) : (tgt_q - cnt_q);
  assign kbit_m1  = kbit_q - 4'd1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      kbit_q   <= '0;
      verify_q <= 1'b0;
      osc_s_q  <= '0;
      cnt_q    <= '0;
      tgt_q    <= '0;
      tol_q    <= '0;
      rest_q   <= '0;
      dly_q    <= '0;
      mode_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lock_q   <= 1'b0;
      ocnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      kbit_q   <= kbit_d;
      verify_q <= verify_d;
      osc_s_q  <= osc_s_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      tol_q    <= tol_d;
      rest_q   <= rest_d;
      dly_q    <= dly_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      lock_q   <= lock_d;
      ocnt_q   <= ocnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    kbit_d   = kbit_q;
    verify_d = verify_q;
    osc_s_d  = {osc_s_q[1:0], bus.i_osc};
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    tol_d    = tol_q;
    rest_d   = rest_q;
    dly_d    = dly_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    lock_d   = lock_q;
    ocnt_d   = ocnt_q;

    case (state_q)
      IDLE: begin
        if (bus.i_abort) begin
          mode_d = 1'b0;
          lock_d = 1'b0;
        end else if (bus.i_start) begin
          tgt_d    = bus.i_target;
          tol_d    = bus.i_tol;
          rest_d   = dly_q;
          dly_d    = 9'h100;
          kbit_d   = 4'd8;
          verify_d = 1'b0;
          busy_d   = 1'b1;
          mode_d   = 1'b1;
          lock_d   = 1'b0;
          tmr_d    = TMR_W'(SETTLE_CYC - 1);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (tmr_q == '0) begin
          cnt_d   = '0;
          tmr_d   = TMR_W'(WIN_CYC - 1);
          state_d = MEASURE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      MEASURE: begin
        if (osc_rise && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        if (tmr_q == '0) state_d = DECIDE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      DECIDE: begin
        ocnt_d = cnt_q;
        if (verify_q) begin
          lock_d  = (diff <= CNT_W'(tol_q));
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          dly_d[kbit_q] = (cnt_q >= tgt_q);
          if (kbit_q != 4'd0) begin
            dly_d[kbit_m1] = 1'b1;
            kbit_d         = kbit_m1;
          end else begin
            verify_d = 1'b1;
          end
          tmr_d   = TMR_W'(SETTLE_CYC - 1);
          state_d = SETTLE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides whatever the active state decided this cycle, including
    // a DECIDE that would otherwise load o_cnt or head for DONE.
    if (bus.i_abort && (state_q inside {SETTLE, MEASURE, DECIDE})) begin
      state_d = IDLE;
      dly_d   = rest_q;
      lock_d  = 1'b0;
      busy_d  = 1'b0;
      mode_d  = 1'b0;
      done_d  = 1'b0;
      ocnt_d  = ocnt_q;
    end
  end

  assign bus.o_dly_sel = dly_q;
  assign bus.o_mode    = mode_q;
  assign bus.o_busy    = busy_q;
  assign bus.o_done    = done_q;
  assign bus.o_lock    = lock_q;
  assign bus.o_cnt     = ocnt_q;

endmodule
